cv32e40p_compressed_decoder_selftest_ctrl: RTL
==============================================

Name: cv32e40p_compressed_decoder_selftest_ctrl

Overview:
- Periodic built-in self-test scheduler for the triplicated compressed decoder.
- Borrows the decoder input slot from the fetch path through a req/gnt handshake and applies a fixed vector set.
- Checks every replica's outputs independently and marks persistently failing replicas broken through the decoder's set_broken input.
- Latent faults are caught while the pipeline is idle, before the voter has to mask them.

Parameters:
- TEST_INTERVAL, 1024, COUNT-state cycles between test attempts (>=2).
- FAIL_LIMIT, 2, consecutive failed runs before a replica is declared broken (1..7).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  self-test enable
- test_req_o  out  1  request ownership of decoder inputs
- test_gnt_i  in  1  ownership granted (fetch mux steers test_instr_o to all three instr_i)
- test_instr_o  out  32  vector driven to decoder
- test_active_o  out  1  high in RUN
- replica_instr_i  in  3x32  per-replica instr_o, before voting
- replica_is_compressed_i  in  3  per-replica is_compressed_o
- replica_illegal_i  in  3  per-replica illegal_instr_o
- is_broken_i  in  3  breakage-monitor state
- set_broken_o  out  3  sticky; to decoder set_broken_i
- fail_mask_o  out  3  per-replica result of last completed run
- test_done_o  out  1  one-cycle pulse on run completion
- fatal_o  out  1  all replicas unusable

Behaviour:
- Reset values: all outputs 0, state COUNT, interval counter = TEST_INTERVAL-1, fail counters 0, vector index 0.
- Vector ROM (upper 16 bits zero for compressed vectors):
  - v0: 0x00000085 -> instr 0x00108093, cmp 1, ill 0.
  - v1: 0x00004515 -> instr 0x00500513, cmp 1, ill 0.
  - v2: 0x0000852E -> instr 0x00B00533, cmp 1, ill 0.
  - v3: 0x00000000 -> ill 1, cmp 1; instr not compared.
  - v4: 0x00000013 -> instr 0x00000013, cmp 0, ill 0.
- COUNT:
  - Counter decrements while enable_i=1 and holds otherwise.
  - At 0 with enable_i=1 -> REQ.
- REQ:
  - test_req_o=1.
  - test_gnt_i=1 -> RUN, index 0.
  - enable_i=0 -> COUNT with counter 0, so the attempt retries immediately on re-enable.
- RUN: 6 cycles, t=0..5.
  - Cycle t (t<=4) drives vector t on test_instr_o; test_instr_o is 0 outside RUN.
  - Cycle t (t>=1) compares replica outputs against expected of vector t-1; the mux is registered, so latency is 1.
  - A mismatch in any compared field sets per-run fail bit m.
  - test_req_o stays 1 throughout.
  - test_gnt_i=0 in any RUN cycle -> abort: fail bits discarded, no counter update, back to REQ. The fetch path wins.
  - enable_i=0 -> abort to COUNT with counter 0.
- EVAL: 1 cycle, req dropped.
  - fail_mask_o <= fail bits; test_done_o=1.
  - Per replica: fail -> consecutive counter +1, saturating at FAIL_LIMIT; pass -> counter cleared.
  - Counter reaching FAIL_LIMIT -> set_broken_o[m] <= 1, sticky until reset. A later pass never clears it.
  - Next state COUNT, counter = TEST_INTERVAL-1.
- Replicas with set_broken_o or is_broken_i set are still tested; results are reported but have no further effect.
- fatal_o = AND over m of (set_broken_o[m] | is_broken_i[m]), registered (1-cycle lag).
- Reset mid-RUN: immediate return to reset values. The grant must be released by the fetch mux when req falls.
- Comparison uses replica (pre-vote) outputs only; the voted outputs are never used.

Test Plan:
- Healthy replicas, TEST_INTERVAL=8, gnt tied high:
  - req rises 8 cycles after reset; test_instr_o runs 0x85, 0x4515, 0x852E, 0x0, 0x13.
  - test_done_o pulses, fail_mask_o=000.
  - Runs repeat every 8+1+6+1 cycles.
- Force replica 1 instr bit 5 stuck-at-1, FAIL_LIMIT=2:
  - First run fail_mask_o=010, set_broken_o=000.
  - Second run set_broken_o=010 in the EVAL cycle.
- Replica 2 fails once, then passes, then fails:
  - Fail counter is cleared by the pass.
  - set_broken_o[2] stays 0 after three runs.
- Drop gnt at RUN t=3:
  - Abort, test_done_o not pulsed, fail counters unchanged, req stays high.
  - Re-grant gives a full 6-cycle run starting at v0.
- Replica 0 illegal stuck-at-0 plus is_broken_i=110:
  - v3 fails on replica 0; after FAIL_LIMIT runs set_broken_o[0]=1.
  - fatal_o rises 1 cycle later.
- enable_i low during COUNT holds the counter; rst_n low mid-RUN clears all outputs asynchronously, including a sticky set_broken_o.

Source files
------------

// File: rtl/cv32e40p_compressed_decoder_selftest_ctrl.sv
// ============================================================================
// Module   : cv32e40p_compressed_decoder_selftest_ctrl
// Brief    : Periodic self-test scheduler for the triplicated compressed
//            decoder; flags persistently failing replicas as broken.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_compressed_decoder_selftest_ctrl #(
    parameter int unsigned TEST_INTERVAL = 1024,
    parameter int unsigned FAIL_LIMIT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    output logic        test_req_o,
    input  logic        test_gnt_i,
    output logic [31:0] test_instr_o,
    output logic        test_active_o,
    input  logic [95:0] replica_instr_i,
    input  logic [2:0]  replica_is_compressed_i,
    input  logic [2:0]  replica_illegal_i,
    input  logic [2:0]  is_broken_i,
    output logic [2:0]  set_broken_o,
    output logic [2:0]  fail_mask_o,
    output logic        test_done_o,
    output logic        fatal_o
);

    localparam int unsigned         c_CNT_W         = (TEST_INTERVAL > 2) ? $clog2(TEST_INTERVAL) : 1;
    localparam logic [c_CNT_W-1:0]  c_INTERVAL_INIT = c_CNT_W'(TEST_INTERVAL - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE       = c_CNT_W'(1);
    localparam logic [2:0]          c_FAIL_LIMIT    = 3'(FAIL_LIMIT);
    localparam logic [2:0]          c_LAST_T        = 3'd5;

    localparam logic [1:0] c_ST_COUNT = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_EVAL  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_interval_cnt;
    logic [2:0]         r_t;
    logic [2:0]         r_fail;
    logic [2:0]         r_fail_mask;
    logic               r_fatal;

    logic [2:0]         w_mismatch;
    logic [2:0]         w_fail_run;
    logic [2:0]         w_set_broken;
    logic [2:0]         w_exp_idx;
    logic               w_last;
    logic               w_eval_upd;
    logic [31:0]        w_vec_instr;
    logic [31:0]        w_exp_instr;
    logic               w_exp_cmp;
    logic               w_exp_ill;
    logic               w_exp_chk;

    assign w_last     = (r_t == c_LAST_T);
    assign w_eval_upd = (r_state == c_ST_RUN) && enable_i && test_gnt_i && w_last;
    assign w_fail_run = r_fail | w_mismatch;
    // Replica outputs lag the driven vector by one cycle (registered fetch mux).
    assign w_exp_idx  = r_t - 3'd1;

    always_comb begin
        w_vec_instr = 32'h0000_0000;
        case (r_t)
            3'd0:    w_vec_instr = 32'h0000_0085;
            3'd1:    w_vec_instr = 32'h0000_4515;
            3'd2:    w_vec_instr = 32'h0000_852E;
            3'd3:    w_vec_instr = 32'h0000_0000;
            3'd4:    w_vec_instr = 32'h0000_0013;
            default: w_vec_instr = 32'h0000_0000;
        endcase
    end

    always_comb begin
        w_exp_instr = 32'h0000_0000;
        w_exp_cmp   = 1'b0;
        w_exp_ill   = 1'b0;
        w_exp_chk   = 1'b0;
        case (w_exp_idx)
            3'd0:    begin w_exp_instr = 32'h0010_8093; w_exp_cmp = 1'b1; w_exp_chk = 1'b1; end
            3'd1:    begin w_exp_instr = 32'h0050_0513; w_exp_cmp = 1'b1; w_exp_chk = 1'b1; end
            3'd2:    begin w_exp_instr = 32'h00B0_0533; w_exp_cmp = 1'b1; w_exp_chk = 1'b1; end
            3'd3:    begin w_exp_cmp = 1'b1; w_exp_ill = 1'b1; end
            3'd4:    begin w_exp_instr = 32'h0000_0013; w_exp_chk = 1'b1; end
            default: begin w_exp_chk = 1'b0; end
        endcase
    end

    for (genvar m = 0; m < 3; m++) begin : g_replica
        logic [2:0] r_fail_cnt;
        logic       r_broken;

        assign w_mismatch[m] = (r_t != 3'd0) &&
                               ((w_exp_chk && (replica_instr_i[32*m +: 32] != w_exp_instr)) ||
                                (replica_is_compressed_i[m] != w_exp_cmp) ||
                                (replica_illegal_i[m] != w_exp_ill));

        // Replicas already marked broken keep being tested but stop counting.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_fail_cnt <= 3'd0;
                r_broken   <= 1'b0;
            end else if (w_eval_upd && !r_broken && !is_broken_i[m]) begin
                if (w_fail_run[m]) begin
                    if (r_fail_cnt != c_FAIL_LIMIT) begin
                        r_fail_cnt <= r_fail_cnt + 3'd1;
                    end
                    if ((r_fail_cnt + 3'd1) == c_FAIL_LIMIT) begin
                        r_broken <= 1'b1;
                    end
                end else begin
                    r_fail_cnt <= 3'd0;
                end
            end
        end

        assign w_set_broken[m] = r_broken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_COUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_COUNT: if (enable_i && (r_interval_cnt == '0)) w_next_state = c_ST_REQ;
            c_ST_REQ: begin
                if (!enable_i)       w_next_state = c_ST_COUNT;
                else if (test_gnt_i) w_next_state = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (!enable_i)        w_next_state = c_ST_COUNT;
                else if (!test_gnt_i) w_next_state = c_ST_REQ;
                else if (w_last)      w_next_state = c_ST_EVAL;
            end
            c_ST_EVAL: w_next_state = c_ST_COUNT;
            default:   w_next_state = c_ST_COUNT;
        endcase
    end

    always_comb begin
        test_req_o    = (r_state == c_ST_REQ) || (r_state == c_ST_RUN);
        test_active_o = (r_state == c_ST_RUN);
        test_done_o   = (r_state == c_ST_EVAL);
        test_instr_o  = (r_state == c_ST_RUN) ? w_vec_instr : 32'h0000_0000;
    end

    // Results are committed on entry to EVAL so they are visible with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_interval_cnt <= c_INTERVAL_INIT;
            r_t            <= 3'd0;
            r_fail         <= 3'd0;
            r_fail_mask    <= 3'd0;
            r_fatal        <= 1'b0;
        end else begin
            r_fatal <= &(w_set_broken | is_broken_i);
            case (r_state)
                c_ST_COUNT: begin
                    if (enable_i && (r_interval_cnt != '0)) begin
                        r_interval_cnt <= r_interval_cnt - c_CNT_ONE;
                    end
                end
                c_ST_REQ: begin
                    if (!enable_i) begin
                        r_interval_cnt <= '0;
                    end else if (test_gnt_i) begin
                        r_t    <= 3'd0;
                        r_fail <= 3'd0;
                    end
                end
                c_ST_RUN: begin
                    if (!enable_i) begin
                        r_interval_cnt <= '0;
                    end else if (test_gnt_i) begin
                        r_t    <= r_t + 3'd1;
                        r_fail <= w_fail_run;
                        if (w_last) begin
                            r_fail_mask <= w_fail_run;
                        end
                    end
                end
                c_ST_EVAL: r_interval_cnt <= c_INTERVAL_INIT;
                default:   r_interval_cnt <= c_INTERVAL_INIT;
            endcase
        end
    end

    assign set_broken_o = w_set_broken;
    assign fail_mask_o  = r_fail_mask;
    assign fatal_o      = r_fatal;

endmodule

`default_nettype wire
